// File: rtl/sram_bus_bridge.sv
// Byte-addressed valid/ready load/store front-end for the word-addressed SRAM (read port A + write port).
// Response 1 cycle after accept (errors, full/empty-mask stores) or 2 cycles (loads, partial stores); held until taken.
module sram_bus_bridge #(
  parameter int num_words    = 4096,
  parameter int l2_num_words = 12,
  parameter int addr_width   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [addr_width-1:0]   i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [3:0]              i_req_be,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [31:0]             o_resp_rdata,
  output logic                    o_resp_err,
  output logic                    o_sram_read_enable_A,
  output logic [l2_num_words-1:0] o_sram_addr_read_A,
  input  logic [31:0]             i_sram_data_read_A,
  output logic                    o_sram_write_enable,
  output logic [l2_num_words-1:0] o_sram_addr_write,
  output logic [31:0]             o_sram_data_to_write
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE, RESP} state_t;

  localparam logic [addr_width-1:0] max_words = addr_width'(num_words);

  state_t                  state, state_nxt;
  logic [l2_num_words-1:0] word_idx, cap_word;
  logic [31:0]             cap_wdata, merged;
  logic [3:0]              cap_be;
  logic                    req_err, accept;

  assign word_idx = i_req_addr[l2_num_words+1:2];
  assign req_err  = (i_req_addr[1:0] != 2'b00) || ((i_req_addr >> 2) >= max_words);
  assign accept   = i_req_valid & o_req_ready;

  // Lanes not enabled keep the word just read back from the SRAM.
  always_comb begin
    merged = i_sram_data_read_A;
    for (int k = 0; k < 4; k++) begin
      if (cap_be[k]) merged[8*k +: 8] = cap_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Everything is gated by reset so an in-flight write is killed the moment reset rises.
  always_comb begin
    state_nxt            = state;
    o_req_ready          = 1'b0;
    o_sram_read_enable_A = 1'b0;
    o_sram_addr_read_A   = '0;
    o_sram_write_enable  = 1'b0;
    o_sram_addr_write    = '0;
    o_sram_data_to_write = '0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          o_req_ready = 1'b1;
          if (i_req_valid) begin
            if (req_err) begin
              state_nxt = RESP;
            end else if (!i_req_write) begin
              o_sram_read_enable_A = 1'b1;
              o_sram_addr_read_A   = word_idx;
              state_nxt            = RD_WAIT;
            end else if (i_req_be == 4'b1111) begin
              o_sram_write_enable  = 1'b1;
              o_sram_addr_write    = word_idx;
              o_sram_data_to_write = i_req_wdata;
              state_nxt            = RESP;
            end else if (i_req_be == 4'b0000) begin
              state_nxt = RESP;
            end else begin
              o_sram_read_enable_A = 1'b1;
              o_sram_addr_read_A   = word_idx;
              state_nxt            = MERGE;
            end
          end
        end
        RD_WAIT: state_nxt = RESP;
        MERGE: begin
          o_sram_write_enable  = 1'b1;
          o_sram_addr_write    = cap_word;
          o_sram_data_to_write = merged;
          state_nxt            = RESP;
        end
        RESP: if (i_resp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_word     <= '0;
      cap_wdata    <= '0;
      cap_be       <= '0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_word  <= word_idx;
        cap_wdata <= i_req_wdata;
        cap_be    <= i_req_be;
      end
      case (state)
        IDLE: begin
          if (accept && state_nxt == RESP) begin
            o_resp_valid <= 1'b1;
            o_resp_rdata <= '0;
            o_resp_err   <= req_err;
          end
        end
        RD_WAIT: begin
          o_resp_valid <= 1'b1;
          o_resp_rdata <= i_sram_data_read_A;
          o_resp_err   <= 1'b0;
        end
        MERGE: begin
          o_resp_valid <= 1'b1;
          o_resp_rdata <= '0;
          o_resp_err   <= 1'b0;
        end
        RESP: if (i_resp_ready) o_resp_valid <= 1'b0;
        default: o_resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
- Upstream front-end for the internal SRAM. It converts a valid/ready byte-addressed load/store request bus into the SRAM's word-addressed, single-cycle-read port signals.
- Uses SRAM read port A and the SRAM write port. Port B stays free for instruction fetch.
- Adds byte-enable support by read-modify-write, plus range and alignment checking.
- Processes one request at a time, with a registered response and back-pressure.

Parameters:
- num_words, 4096: SRAM depth in 32-bit words; must match the attached SRAM.
- l2_num_words, 12: log2(num_words); SRAM address width.
- addr_width, 32: width of the byte address on the request bus.

Ports:
- i_clk  in  1  clock, posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  bridge can accept a request this cycle.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_addr  in  addr_width  byte address.
- i_req_wdata  in  32  store data, little-endian byte lanes.
- i_req_be  in  4  store byte enables; bit k selects bits [8k+7:8k].
- o_resp_valid  out  1  response present.
- i_resp_ready  in  1  consumer takes the response.
- o_resp_rdata  out  32  load data (0 for stores and for errors).
- o_resp_err  out  1  request was rejected (out of range or misaligned).
- o_sram_read_enable_A  out  1  to SRAM read enable A.
- o_sram_addr_read_A  out  l2_num_words  to SRAM read address A.
- i_sram_data_read_A  in  32  from SRAM read data A; valid the cycle after the read is issued.
- o_sram_write_enable  out  1  to SRAM write enable.
- o_sram_addr_write  out  l2_num_words  to SRAM write address.
- o_sram_data_to_write  out  32  to SRAM write data.

Behaviour:
- States: IDLE, RD_WAIT, MERGE, RESP. State is reset asynchronously to IDLE.
- Reset values:
  - o_resp_valid=0, o_resp_rdata=0, o_resp_err=0.
  - All SRAM enables 0, SRAM address and data outputs 0.
  - o_req_ready=0 while i_rst is high.
- Handshakes:
  - o_req_ready=1 only in IDLE. A request is accepted when i_req_valid & o_req_ready (cycle N).
  - A response transfers when o_resp_valid & i_resp_ready. RESP then goes to IDLE, so the next request is accepted no earlier than the following cycle.
- Word index = i_req_addr[l2_num_words+1:2].
- Error check: err = (i_req_addr[1:0]!=0) | (i_req_addr >> 2 >= num_words).
- SRAM-side outputs are combinational from the current state and the accepted request.
  - Request fields are captured into internal registers at accept and used in later states.
- Accept with err:
  - No SRAM enable is asserted.
  - Response registered: o_resp_err=1, o_resp_rdata=0, o_resp_valid=1 at N+1, state RESP.
- Load:
  - Cycle N: read_enable_A=1, read address = word index. State goes to RD_WAIT.
  - Cycle N+1: i_sram_data_read_A is captured into o_resp_rdata; o_resp_valid=1 at N+2.
- Store with be=1111:
  - Cycle N: write_enable=1, write address = word index, write data = i_req_wdata.
  - o_resp_valid=1 at N+1.
- Store with be=0000:
  - No SRAM access; o_resp_valid=1 at N+1.
- Store with partial be:
  - Cycle N: read issued as for a load. State goes to MERGE.
  - Cycle N+1: write_enable=1 with merged data. Each byte lane k takes the captured wdata byte if be[k], else the i_sram_data_read_A byte.
  - o_resp_valid=1 at N+2.
- Stores always respond with o_resp_rdata=0 and o_resp_err=0.
- The response is held stable (valid, rdata, err) until it is accepted.
  - No SRAM enable is asserted while in RESP.
  - SRAM enables are single-cycle pulses.
- Requests are serialized, so there is no read-after-write hazard. A load issued immediately after a store response sees the stored data.
- Reset mid-operation:
  - Asserting i_rst during RD_WAIT or MERGE forces all SRAM enables low immediately.
  - A partial store is therefore dropped entirely: the SRAM word is unchanged, no response is produced, and the bridge returns to IDLE.
- Inputs i_req_* are ignored outside IDLE.

Test Plan:
- Full-word store then load: store addr 0x10, wdata 0xDEADBEEF, be 1111, then load 0x10.
  - Response: valid at N+1 for the store, err=0.
  - Load response at N+2 with rdata=0xDEADBEEF.
  - Exactly one write pulse, to address 4.
- Partial store: after the full-word store, store addr 0x10, wdata 0x0000AA00, be 0010, then load 0x10.
  - Read pulse at N, write pulse at N+1, response at N+2.
  - Load returns 0xDEADAAEF.
- Errors: load 0x4000 (word 4096), then store 0x11 with be 1111.
  - Each responds at N+1 with err=1, rdata=0.
  - No SRAM enable asserted.
- Back-pressure: load, with i_resp_ready low for 5 cycles.
  - o_resp_valid and rdata stay stable; o_req_ready=0 throughout.
  - After the handshake, o_req_ready=1 the next cycle.
- be=0000 store to 0x20 holding 0x12345678:
  - No SRAM access; response at N+1.
  - A following load returns 0x12345678.
- Reset mid-RMW: word 8 holds 0x11223344; issue a be=0001 store, and assert i_rst during MERGE.
  - No write pulse; no response.
  - After reset, a load of word 8 returns 0x11223344.
